z80_waitstate_generator: RTL and testbench
==========================================

Z80_WAITSTATE_GENERATOR -- requirements
Module: z80_waitstate_generator

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset: i_clk samples all inputs on its rising edge, and i_reset low at a rising edge resets the block.
REQ-002 i_clk  input  1  Z80 system clock; all state changes on its rising edge.
REQ-003 i_reset  input  1  synchronous active-low reset.
REQ-004 i_iorq_n  input  1  active-low I/O request for a wait-generated I/O cycle (already qualified externally by address decode).
REQ-005 i_device  input  2  index of the target I/O device of the current cycle.
REQ-006 i_cs_n  input  1  active-low chip select of the generator's own configuration registers (I/O-qualified externally).
REQ-007 i_wr_n  input  1  active-low Z80 write strobe.
REQ-008 i_addr  input  2  configuration register index (device 0..3).
REQ-009 i_data  input  8  write data from the Z80 bus.
REQ-010 o_data  output  8  configuration readback data.
REQ-011 o_wait  output  1  active-high wait request to the Z80 WAIT logic; high = insert wait state.

Function
REQ-012 The block SHALL hold four 8-bit wait registers WS[0..3], one per device.
REQ-013 Config write: a rising edge with i_cs_n=0 and i_wr_n=0 SHALL load WS[i_addr] <= i_data; a repeated write over consecutive edges SHALL be harmless.
REQ-014 WS[d] SHALL equal the total I/O wait states for device d, including the Z80 automatic TW; the block SHALL assert o_wait for max(WS[d]-1, 0) clocks.
REQ-015 Cycle start SHALL be the first rising edge with i_iorq_n=0, i_cs_n=1 and armed=1; armed SHALL clear at start and set again on any edge with i_iorq_n=1.
REQ-016 At cycle start with WS[i_device] >= 2: o_wait <= 1 and cnt <= WS[i_device]-2; with WS < 2, o_wait SHALL stay 0.
REQ-017 While o_wait=1 and i_iorq_n=0: if cnt != 0 then cnt <= cnt-1, else o_wait <= 0.
REQ-018 o_wait SHALL be registered, with no combinational path from inputs; it SHALL rise on the same edge that first samples i_iorq_n low.
REQ-019 i_iorq_n returning high while o_wait=1 SHALL abort the cycle: o_wait <= 0 and cnt <= 0 on that edge.
REQ-020 Config accesses (i_cs_n=0) SHALL never start a wait sequence.
REQ-021 WS=255 SHALL give 254 wait clocks; the 8-bit counter SHALL not wrap.
REQ-022 A new cycle SHALL use the WS value sampled at its start; later register writes SHALL not affect a running count.

Reset
REQ-023 i_reset=0 at a rising edge SHALL clear WS[0..3] to 0, cnt to 0 and o_wait to 0, and SHALL set armed to 1; it SHALL take priority over all other actions, including mid-wait.
REQ-024 o_data SHALL be 0 during and after reset until a readback occurs.

Configuration
REQ-025 Macro Z80_WSG_READBACK_EN: when defined, o_data = WS[i_addr] combinationally whenever i_cs_n=0 and i_wr_n=1, otherwise 8'h00.
REQ-026 Without Z80_WSG_READBACK_EN, o_data SHALL be constant 8'h00 and no readback logic SHALL be synthesized.

Verification
REQ-027 Config write: i_cs_n=0, i_wr_n=0, i_addr=0, i_data=3 -> WS[0]=3, and o_wait stays 0.
REQ-028 Wait count: WS[0]=3, then i_iorq_n=0 with i_device=0 -> o_wait=1 for exactly 2 clocks from the first low-sampling edge, and 0 on the third edge.
REQ-029 Zero/one setting: WS[2]=1 and i_device=2 cycle -> o_wait never asserts; WS[2]=2 -> exactly 1 clock.
REQ-030 Abort: WS[1]=10, i_iorq_n raised after 3 wait clocks -> o_wait=0 on the next edge; the next cycle again gives 9 clocks.
REQ-031 Reset mid-wait: i_reset=0 during o_wait=1 -> o_wait=0 and all WS=0; the following cycle gives no waits.
REQ-032 Readback (with Z80_WSG_READBACK_EN): WS[3]=8'hA5, i_cs_n=0, i_wr_n=1, i_addr=3 -> o_data=8'hA5; without the macro -> o_data=8'h00.

Source files
------------

// File: rtl/z80_waitstate_generator.sv
// z80_waitstate_generator
// Purpose: programmable I/O wait-state generator for a Z80 bus. Each of four
// I/O devices has an 8-bit register holding its total wait-state count
// (including the Z80's automatic TW). During an I/O cycle the block drives
// o_wait high for max(WS[d]-1, 0) clocks.
//
// Ports:
//   i_clk     - system clock, all state changes on its rising edge
//   i_reset   - synchronous active-low reset
//   i_iorq_n  - active-low I/O request (address-qualified externally)
//   i_device  - target device index of the current I/O cycle
//   i_cs_n    - active-low chip select of the configuration registers
//   i_wr_n    - active-low write strobe
//   i_addr    - configuration register index
//   i_data    - configuration write data
//   o_data    - configuration readback data (0 unless readback enabled)
//   o_wait    - registered wait request, high = insert wait state
//
// Build option: define Z80_WSG_READBACK_EN to enable combinational readback
// of WS[i_addr] on o_data while i_cs_n=0 and i_wr_n=1.
module z80_waitstate_generator (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_iorq_n,
  input  logic [1:0] i_device,
  input  logic       i_cs_n,
  input  logic       i_wr_n,
  input  logic [1:0] i_addr,
  input  logic [7:0] i_data,
  output logic [7:0] o_data,
  output logic       o_wait
);

  logic [7:0] r_ws [0:3];
  logic [7:0] r_cnt;
  logic       r_wait;
  logic       r_armed;

  logic       w_cfg_wr;
  logic       w_start;
  logic [7:0] w_ws_sel;

  assign w_cfg_wr = ~i_cs_n & ~i_wr_n;
  // A configuration access never starts a cycle; armed prevents a long
  // IORQ-low period from restarting once the count has finished.
  assign w_start  = ~i_iorq_n & i_cs_n & r_armed;
  assign w_ws_sel = r_ws[i_device];

  // Configuration registers.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_ws[0] <= 8'h00;
      r_ws[1] <= 8'h00;
      r_ws[2] <= 8'h00;
      r_ws[3] <= 8'h00;
    end else if (w_cfg_wr) begin
      r_ws[i_addr] <= i_data;
    end else begin
      r_ws[i_addr] <= r_ws[i_addr];
    end
  end

  // Cycle arming: cleared at cycle start, re-armed whenever IORQ is high.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_armed <= 1'b1;
    end else if (i_iorq_n) begin
      r_armed <= 1'b1;
    end else if (w_start) begin
      r_armed <= 1'b0;
    end else begin
      r_armed <= r_armed;
    end
  end

  // Wait counter. cnt holds the remaining extra clocks after the current
  // one, so WS is latched as WS-2 at start; it only counts down to zero and
  // therefore cannot wrap. Later config writes do not touch a running count.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_wait <= 1'b0;
      r_cnt  <= 8'h00;
    end else if (r_wait) begin
      if (i_iorq_n) begin
        r_wait <= 1'b0;
        r_cnt  <= 8'h00;
      end else if (r_cnt != 8'h00) begin
        r_cnt  <= r_cnt - 8'd1;
      end else begin
        r_wait <= 1'b0;
      end
    end else if (w_start && (w_ws_sel >= 8'd2)) begin
      r_wait <= 1'b1;
      r_cnt  <= w_ws_sel - 8'd2;
    end else begin
      r_wait <= 1'b0;
      r_cnt  <= r_cnt;
    end
  end

  assign o_wait = r_wait;

`ifdef Z80_WSG_READBACK_EN
  assign o_data = (!i_cs_n && i_wr_n) ? r_ws[i_addr] : 8'h00;
`else
  assign o_data = 8'h00;
`endif

endmodule

// File: tb/tb_z80_waitstate_generator.sv
// Directed testbench for z80_waitstate_generator. Inputs are driven 1 time
// unit after a rising edge and outputs are sampled there too.
module tb_z80_waitstate_generator;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_iorq_n;
  logic [1:0] i_device;
  logic       i_cs_n;
  logic       i_wr_n;
  logic [1:0] i_addr;
  logic [7:0] i_data;
  logic [7:0] o_data;
  logic       o_wait;

  int n_checks = 0;
  int n_fail   = 0;
  int waits;

  z80_waitstate_generator dut (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_iorq_n (i_iorq_n),
    .i_device (i_device),
    .i_cs_n   (i_cs_n),
    .i_wr_n   (i_wr_n),
    .i_addr   (i_addr),
    .i_data   (i_data),
    .o_data   (o_data),
    .o_wait   (o_wait)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
    i_cs_n = 1'b0; i_wr_n = 1'b0; i_addr = a; i_data = d;
    tick();
    i_cs_n = 1'b1; i_wr_n = 1'b1;
  endtask

  // Hold IORQ low for 'hold' edges, count edges leaving o_wait high, then
  // release IORQ for one edge.
  task automatic run_cycle(input logic [1:0] dev, input int hold, output int cnt);
    cnt = 0;
    i_device = dev; i_iorq_n = 1'b0;
    for (int k = 0; k < hold; k++) begin
      tick();
      if (o_wait) cnt++;
    end
    i_iorq_n = 1'b1;
    tick();
  endtask

  initial begin
    i_reset = 1'b0; i_iorq_n = 1'b1; i_device = 2'd0;
    i_cs_n = 1'b1; i_wr_n = 1'b1; i_addr = 2'd0; i_data = 8'h00;
    tick(); tick();
    chk("reset_wait", int'(o_wait), 0);
    chk("reset_data", int'(o_data), 0);
    i_reset = 1'b1;
    tick();
    chk("post_reset_data", int'(o_data), 0);

    // Config write, held over two edges, must not raise o_wait.
    i_cs_n = 1'b0; i_wr_n = 1'b0; i_addr = 2'd0; i_data = 8'd3;
    tick();
    chk("cfg_wr_wait0", int'(o_wait), 0);
    tick();
    chk("cfg_wr_wait1", int'(o_wait), 0);
    i_cs_n = 1'b1; i_wr_n = 1'b1;
    tick();

    // WS[0]=3: high after edges 1 and 2, low after edge 3.
    i_device = 2'd0; i_iorq_n = 1'b0;
    tick(); chk("ws3_edge1", int'(o_wait), 1);
    tick(); chk("ws3_edge2", int'(o_wait), 1);
    tick(); chk("ws3_edge3", int'(o_wait), 0);
    tick(); chk("ws3_edge4", int'(o_wait), 0);
    i_iorq_n = 1'b1;
    tick();

    // WS[2]=1 gives no waits, WS[2]=2 gives one, WS[2]=0 gives none.
    cfg_write(2'd2, 8'd1);
    run_cycle(2'd2, 5, waits); chk("ws1_count", waits, 0);
    cfg_write(2'd2, 8'd2);
    run_cycle(2'd2, 5, waits); chk("ws2_count", waits, 1);
    cfg_write(2'd2, 8'd0);
    run_cycle(2'd2, 5, waits); chk("ws0_count", waits, 0);

    // Abort after 3 wait clocks, then a full cycle of 9.
    cfg_write(2'd1, 8'd10);
    i_device = 2'd1; i_iorq_n = 1'b0;
    tick(); tick(); tick();
    chk("abort_pre", int'(o_wait), 1);
    i_iorq_n = 1'b1;
    tick(); chk("abort_edge", int'(o_wait), 0);
    tick(); chk("abort_idle", int'(o_wait), 0);
    run_cycle(2'd1, 14, waits); chk("after_abort_count", waits, 9);

    // A config access with IORQ low must not start a sequence.
    i_device = 2'd1; i_iorq_n = 1'b0; i_cs_n = 1'b0; i_wr_n = 1'b1; i_addr = 2'd1;
    tick(); chk("cfg_no_start0", int'(o_wait), 0);
    tick(); chk("cfg_no_start1", int'(o_wait), 0);
    i_iorq_n = 1'b1; i_cs_n = 1'b1;
    tick();

    // Maximum setting: 254 waits, no wrap.
    cfg_write(2'd3, 8'd255);
    run_cycle(2'd3, 260, waits); chk("ws255_count", waits, 254);

    // Rewriting WS mid-count does not affect the running cycle.
    cfg_write(2'd3, 8'd5);
    waits = 0;
    i_device = 2'd3; i_iorq_n = 1'b0;
    tick(); if (o_wait) waits++;
    i_cs_n = 1'b0; i_wr_n = 1'b0; i_addr = 2'd3; i_data = 8'd2;
    tick(); if (o_wait) waits++;
    i_cs_n = 1'b1; i_wr_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick(); if (o_wait) waits++;
    end
    i_iorq_n = 1'b1;
    tick();
    chk("midwrite_count", waits, 4);
    run_cycle(2'd3, 5, waits); chk("newws_count", waits, 1);

    // Readback of WS[3].
    cfg_write(2'd3, 8'hA5);
    i_cs_n = 1'b0; i_wr_n = 1'b1; i_addr = 2'd3;
    #1;
`ifdef Z80_WSG_READBACK_EN
    chk("readback", int'(o_data), 8'hA5);
`else
    chk("readback", int'(o_data), 0);
`endif
    i_cs_n = 1'b1;
    #1;
    chk("readback_idle", int'(o_data), 0);
    tick();

    // Reset in the middle of a wait.
    i_device = 2'd1; i_iorq_n = 1'b0;
    tick(); tick();
    chk("pre_reset_wait", int'(o_wait), 1);
    i_reset = 1'b0;
    tick(); chk("midwait_reset", int'(o_wait), 0);
    i_reset = 1'b1; i_iorq_n = 1'b1;
    tick();
    run_cycle(2'd0, 5, waits); chk("rst_dev0", waits, 0);
    run_cycle(2'd1, 5, waits); chk("rst_dev1", waits, 0);
    run_cycle(2'd2, 5, waits); chk("rst_dev2", waits, 0);
    run_cycle(2'd3, 5, waits); chk("rst_dev3", waits, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
